// File: rtl/wave_capture_ctrl_if.sv
// wave_capture_ctrl_if: command, FADC, SRAM and FT245 pin bundle for the waveform capture controller
// Ports (master = controller side):
//   in : cmd[7:0], cmd_vld, bank, len, wavex, dx_i, txe (active low)
//   out: adclk, adx, dx_o, dx_oe, cex (SRAM OE_N), cey (SRAM WE_N), wr, usb_do, usb_oe,
//        busy, done, stat[3:0], wfstat[7:0]
interface wave_capture_ctrl_if #(
    parameter int ADC_W     = 10,
    parameter int ADRS_W    = 20,
    parameter int SRAM_W    = 16,
    parameter int BANK_LOG2 = 2
);
    logic [7:0]           cmd;
    logic                 cmd_vld;
    logic [BANK_LOG2-1:0] bank;
    logic [ADRS_W-1:0]    len;
    logic [ADC_W-1:0]     wavex;
    logic                 adclk;
    logic [ADRS_W-1:0]    adx;
    logic [SRAM_W-1:0]    dx_o;
    logic [SRAM_W-1:0]    dx_i;
    logic                 dx_oe;
    logic                 cex;
    logic                 cey;
    logic                 txe;
    logic                 wr;
    logic [7:0]           usb_do;
    logic                 usb_oe;
    logic                 busy;
    logic                 done;
    logic [3:0]           stat;
    logic [7:0]           wfstat;
    modport master (
        input  cmd, cmd_vld, bank, len, wavex, dx_i, txe,
        output adclk, adx, dx_o, dx_oe, cex, cey, wr, usb_do, usb_oe, busy, done, stat, wfstat
    );
    modport slave (
        output cmd, cmd_vld, bank, len, wavex, dx_i, txe,
        input  adclk, adx, dx_o, dx_oe, cex, cey, wr, usb_do, usb_oe, busy, done, stat, wfstat
    );
endinterface

// File: rtl/wave_capture_ctrl.sv
// wave_capture_ctrl: FADC boxcar capture into banked SRAM, bank clear, and FT245 readout
// Ports:
//   clk_i  : system clock
//   rst_ni : asynchronous reset, active low
//   wc     : wave_capture_ctrl_if.master (command strobe, FADC data/clock, SRAM pins, FT245 pins, status)
module wave_capture_ctrl #(
    parameter int ADC_W     = 10,
    parameter int AVG_LOG2  = 3,
    parameter int DECIM     = 8192,
    parameter int ADRS_W    = 20,
    parameter int SRAM_W    = 16,
    parameter int BANK_LOG2 = 2,
    parameter int OFFSET    = 100
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    wave_capture_ctrl_if.master wc
);
    localparam int NAVG  = 1 << AVG_LOG2;
    localparam int SUM_W = ADC_W + AVG_LOG2;
    localparam int PTR_W = ADRS_W - BANK_LOG2;
    localparam int CNT_W = ADRS_W + 1;
    localparam int TIM_W = $clog2(DECIM);
    localparam logic [CNT_W-1:0] BANK_N = CNT_W'(1) << PTR_W;

    // state encodings double as the LED status code
    typedef enum logic [3:0] {IDLE = 4'd0, CLR = 4'd1, CAP = 4'd3, RD = 4'd5} state_e;
    typedef enum logic [2:0] {R_ADR, R_LAT, R_WAIT, R_WRH, R_WRL} rph_e;

    logic [1:0]                 ph_q;
    logic [NAVG-1:0][ADC_W-1:0] hist_q;
    logic [SUM_W-1:0]           sum_q, sum_d;
    logic [ADC_W-1:0]           avg, store;
    logic [15:0]                rd16;

    state_e               state_q;
    rph_e                 rph_q;
    logic [1:0]           sub_q;
    logic                 hi_q;
    logic [2:0]           step_q;
    logic [TIM_W-1:0]     tim_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [CNT_W-1:0]     cnt_q, n_q;
    logic [BANK_LOG2-1:0] bank_q;
    logic [SRAM_W-1:0]    rdat_q;
    logic [ADRS_W-1:0]    adx_q;
    logic [SRAM_W-1:0]    dx_q;
    logic                 dx_oe_q, cex_q, cey_q, wr_q, usb_oe_q, done_q;
    logic [7:0]           usb_do_q;

    // FADC sample is taken on the last phase of each ADCLK period; the oldest
    // history entry leaves the sum as the new one enters
    always_comb begin
        sum_d = (ph_q == 2'd3) ? sum_q + SUM_W'(wc.wavex) - SUM_W'(hist_q[NAVG-1]) : sum_q;
        avg   = sum_q[SUM_W-1:AVG_LOG2];
        store = (avg > ADC_W'(OFFSET)) ? avg - ADC_W'(OFFSET) : '0;
        rd16  = 16'(rdat_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ph_q   <= '0;
            sum_q  <= '0;
            hist_q <= '0;
        end else begin
            ph_q  <= ph_q + 2'd1;
            sum_q <= sum_d;
            if (ph_q == 2'd3)
                hist_q <= {hist_q[NAVG-2:0], wc.wavex};
        end
    end

    // sub_q walks the shared write cycle: 1=c0 (address/data up), 2=c1 (WE_N low), 3=c2 (WE_N high);
    // 0 means no write in flight (capture waiting for the decimation timer)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rph_q    <= R_ADR;
            sub_q    <= '0;
            hi_q     <= 1'b0;
            step_q   <= '0;
            tim_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            n_q      <= '0;
            bank_q   <= '0;
            rdat_q   <= '0;
            adx_q    <= '0;
            dx_q     <= '0;
            dx_oe_q  <= 1'b0;
            cex_q    <= 1'b1;
            cey_q    <= 1'b1;
            wr_q     <= 1'b0;
            usb_do_q <= '0;
            usb_oe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wc.cmd_vld && wc.cmd == 8'd6) begin
                state_q  <= IDLE;
                sub_q    <= '0;
                cey_q    <= 1'b1;
                cex_q    <= 1'b1;
                dx_oe_q  <= 1'b0;
                wr_q     <= 1'b0;
                usb_oe_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (wc.cmd_vld) begin
                        bank_q <= wc.bank;
                        n_q    <= (wc.len == '0) ? BANK_N : CNT_W'(wc.len);
                        cnt_q  <= '0;
                        tim_q  <= '0;
                        case (wc.cmd)
                            8'd1: begin
                                state_q <= CLR;
                                adx_q   <= {wc.bank, ptr_q};
                                dx_q    <= '0;
                                dx_oe_q <= 1'b1;
                                sub_q   <= 2'd1;
                            end
                            8'd3: begin
                                state_q <= CAP;
                                sub_q   <= 2'd0;
                            end
                            8'd4: ptr_q <= '0;
                            8'd5: begin
                                state_q <= RD;
                                adx_q   <= {wc.bank, ptr_q};
                                cex_q   <= 1'b0;
                                rph_q   <= R_ADR;
                            end
                            default: ;
                        endcase
                    end
                    CLR, CAP: begin
                        if (state_q == CAP)
                            tim_q <= (tim_q == TIM_W'(DECIM - 1)) ? '0 : tim_q + 1'b1;
                        case (sub_q)
                            2'd0: if (state_q == CAP && tim_q == TIM_W'(DECIM - 1)) begin
                                adx_q   <= {bank_q, ptr_q};
                                dx_q    <= SRAM_W'(store);
                                dx_oe_q <= 1'b1;
                                sub_q   <= 2'd1;
                            end
                            2'd1: begin
                                cey_q <= 1'b0;
                                sub_q <= 2'd2;
                            end
                            2'd2: begin
                                cey_q <= 1'b1;
                                ptr_q <= ptr_q + 1'b1;
                                sub_q <= 2'd3;
                            end
                            default: if (cnt_q == n_q - 1'b1) begin
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                                dx_oe_q <= 1'b0;
                                sub_q   <= 2'd0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                                // clear runs back to back; capture drops the bus until the next tick
                                if (state_q == CLR) begin
                                    adx_q <= {bank_q, ptr_q};
                                    sub_q <= 2'd1;
                                end else begin
                                    dx_oe_q <= 1'b0;
                                    sub_q   <= 2'd0;
                                end
                            end
                        endcase
                    end
                    RD: case (rph_q)
                        R_ADR: rph_q <= R_LAT;
                        R_LAT: begin
                            rdat_q <= wc.dx_i;
                            cex_q  <= 1'b1;
                            ptr_q  <= ptr_q + 1'b1;
                            hi_q   <= 1'b0;
                            rph_q  <= R_WAIT;
                        end
                        // TXE is only looked at here, so a byte already started never stalls
                        R_WAIT: if (!wc.txe) begin
                            usb_do_q <= hi_q ? rd16[15:8] : rd16[7:0];
                            usb_oe_q <= 1'b1;
                            wr_q     <= 1'b1;
                            step_q   <= '0;
                            rph_q    <= R_WRH;
                        end
                        R_WRH: begin
                            step_q <= step_q + 1'b1;
                            if (step_q == 3'd4) begin
                                wr_q   <= 1'b0;
                                step_q <= '0;
                                rph_q  <= R_WRL;
                            end
                        end
                        default: begin
                            step_q <= step_q + 1'b1;
                            if (step_q == 3'd5) begin
                                usb_oe_q <= 1'b0;
                                if (!hi_q) begin
                                    hi_q  <= 1'b1;
                                    rph_q <= R_WAIT;
                                end else if (cnt_q == n_q - 1'b1) begin
                                    done_q  <= 1'b1;
                                    state_q <= IDLE;
                                end else begin
                                    cnt_q <= cnt_q + 1'b1;
                                    adx_q <= {bank_q, ptr_q};
                                    cex_q <= 1'b0;
                                    rph_q <= R_ADR;
                                end
                            end
                        end
                    endcase
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign wc.adclk  = ph_q[1];
    assign wc.adx    = adx_q;
    assign wc.dx_o   = dx_q;
    assign wc.dx_oe  = dx_oe_q;
    assign wc.cex    = cex_q;
    assign wc.cey    = cey_q;
    assign wc.wr     = wr_q;
    assign wc.usb_do = usb_do_q;
    assign wc.usb_oe = usb_oe_q;
    assign wc.busy   = state_q != IDLE;
    assign wc.done   = done_q;
    assign wc.stat   = state_q;
    assign wc.wfstat = avg[ADC_W-1 -: 8];
endmodule

// File: tb/tb_wave_capture_ctrl.sv
// tb_wave_capture_ctrl: directed checks of ramp averaging, capture, clear, readout, abort and reset
module tb_wave_capture_ctrl;
    localparam int ADC_W = 10, ADRS_W = 20, SRAM_W = 16, BANK_LOG2 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wave_capture_ctrl_if #(.ADC_W(ADC_W), .ADRS_W(ADRS_W), .SRAM_W(SRAM_W), .BANK_LOG2(BANK_LOG2)) wc ();

    wave_capture_ctrl #(
        .ADC_W(ADC_W), .AVG_LOG2(3), .DECIM(16), .ADRS_W(ADRS_W),
        .SRAM_W(SRAM_W), .BANK_LOG2(BANK_LOG2), .OFFSET(100)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .wc    (wc)
    );

    logic [15:0] mem [16];
    assign wc.dx_i = !wc.cex ? mem[wc.adx[3:0]] : '0;

    typedef struct packed {logic [19:0] a; logic [15:0] d; logic oe;} wr_t;
    typedef struct {
        logic [7:0]  cmd;
        logic [1:0]  bank;
        logic [19:0] len;
        logic [9:0]  wav;
        int          nw;
        logic [15:0] dat;
        logic [19:0] base;
        bit          dn;
    } vec_t;

    int errors = 0, checks = 0;
    wr_t wlog[$];
    logic [7:0] bytes[$];
    int lens[$];
    int we_long = 0, done_cnt = 0, oe_bad = 0, hilen = 0;
    logic prev_cey = 1'b1, prev_wr = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (!wc.cey) begin
                wlog.push_back({wc.adx, wc.dx_o, wc.dx_oe});
                if (!prev_cey) we_long <= we_long + 1;
            end
            if (wc.done) done_cnt <= done_cnt + 1;
            if (wc.wr && !prev_wr) begin
                bytes.push_back(wc.usb_do);
                hilen <= 1;
            end else if (wc.wr) hilen <= hilen + 1;
            if (!wc.wr && prev_wr) lens.push_back(hilen);
            if (wc.wr && !wc.usb_oe) oe_bad <= oe_bad + 1;
        end
        prev_cey <= wc.cey;
        prev_wr  <= wc.wr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [7:0] c, input logic [1:0] b, input logic [19:0] l);
        @(negedge clk);
        wc.cmd = c; wc.bank = b; wc.len = l; wc.cmd_vld = 1'b1;
        @(negedge clk);
        wc.cmd_vld = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit got);
        got = 1'b0;
        for (int i = 0; i < lim && !got; i++) begin
            @(negedge clk);
            if (wc.done) got = 1'b1;
        end
    endtask

    task automatic check_writes(input string tag, input int nw, input logic [19:0] base, input logic [15:0] dat);
        chk({tag, "_nwrites"}, wlog.size(), nw);
        for (int j = 0; j < nw && j < wlog.size(); j++) begin
            chk({tag, "_adx"}, wlog[j].a, base + 20'(j));
            chk({tag, "_data"}, wlog[j].d, dat);
            chk({tag, "_oe"}, wlog[j].oe, 1);
        end
    endtask

    vec_t vt[6];

    initial begin
        bit got, ap;
        int k, r0, r1, nr, d0, w0, bad;
        vt[0] = '{8'd3, 2'd1, 20'd4, 10'd300, 4, 16'd200, 20'h40000, 1'b1};
        vt[1] = '{8'd3, 2'd0, 20'd2, 10'd50,  2, 16'd0,   20'h00000, 1'b1};
        vt[2] = '{8'd1, 2'd2, 20'd3, 10'd0,   3, 16'd0,   20'h80000, 1'b1};
        vt[3] = '{8'd2, 2'd0, 20'd5, 10'd0,   0, 16'd0,   20'h00000, 1'b0};
        vt[4] = '{8'd3, 2'd3, 20'd1, 10'd101, 1, 16'd1,   20'hC0000, 1'b1};
        vt[5] = '{8'd3, 2'd0, 20'd1, 10'd100, 1, 16'd0,   20'h00000, 1'b1};
        for (int i = 0; i < 16; i++) mem[i] = '0;
        wc.cmd = '0; wc.cmd_vld = 1'b0; wc.bank = '0; wc.len = '0; wc.wavex = '0; wc.txe = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cex", wc.cex, 1);
        chk("rst_cey", wc.cey, 1);
        chk("rst_wr", wc.wr, 0);
        chk("rst_usb_oe", wc.usb_oe, 0);
        chk("rst_dx_oe", wc.dx_oe, 0);
        chk("rst_adx", wc.adx, 0);
        chk("rst_busy", wc.busy, 0);
        chk("rst_stat", wc.stat, 0);
        chk("rst_wfstat", wc.wfstat, 0);
        chk("rst_adclk", wc.adclk, 0);
        rst_n = 1'b1;

        // ramp: sample k captured at each ADCLK fall; boxcar of 8 gives avg k-4, WFSTAT = avg>>2
        ap = 1'b0; k = 0; nr = 0; r0 = 0; r1 = 0;
        for (int c = 0; c < 600 && k <= 100; c++) begin
            @(negedge clk);
            if (!ap && wc.adclk) begin
                if (nr == 1) r0 = c;
                if (nr == 2) r1 = c;
                nr++;
            end
            if (ap && !wc.adclk) begin
                if (k == 20) chk("wfstat_k20", wc.wfstat, 4);
                if (k == 40) chk("wfstat_k40", wc.wfstat, 9);
                if (k == 100) chk("wfstat_k100", wc.wfstat, 24);
                k++;
                wc.wavex = 10'(k);
            end
            ap = wc.adclk;
        end
        chk("adclk_period", r1 - r0, 4);
        chk("ramp_samples", k, 101);

        for (int i = 0; i < 6; i++) begin
            wc.wavex = vt[i].wav;
            repeat (50) @(negedge clk);
            issue(8'd4, 2'd0, 20'd0);
            wlog.delete();
            w0 = we_long;
            issue(vt[i].cmd, vt[i].bank, vt[i].len);
            wait_done(vt[i].dn ? 400 : 60, got);
            chk($sformatf("vec%0d_done", i), got, vt[i].dn);
            @(negedge clk);
            check_writes($sformatf("vec%0d", i), vt[i].nw, vt[i].base, vt[i].dat);
            chk($sformatf("vec%0d_we_width", i), we_long - w0, 0);
            chk($sformatf("vec%0d_busy", i), wc.busy, 0);
        end

        // abort on c1 of a full-bank clear
        issue(8'd4, 2'd0, 20'd0);
        issue(8'd1, 2'd0, 20'd0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (!wc.cey) got = 1'b1;
        end
        chk("abort_we_seen", got, 1);
        chk("abort_stat_clr", wc.stat, 1);
        d0 = done_cnt;
        wc.cmd = 8'd6; wc.cmd_vld = 1'b1;
        @(negedge clk);
        wc.cmd_vld = 1'b0;
        chk("abort_cey", wc.cey, 1);
        chk("abort_dx_oe", wc.dx_oe, 0);
        chk("abort_busy", wc.busy, 0);
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        issue(8'd4, 2'd0, 20'd0);
        wlog.delete();
        issue(8'd1, 2'd0, 20'd3);
        wait_done(100, got);
        chk("clr3_done", got, 1);
        @(negedge clk);
        check_writes("clr3", 3, 20'h0, 16'h0);

        // readout with TXE stall before the third byte
        mem[0] = 16'h1234; mem[1] = 16'hABCD;
        issue(8'd4, 2'd0, 20'd0);
        bytes.delete(); lens.delete();
        issue(8'd5, 2'd0, 20'd2);
        for (int i = 0; i < 300 && bytes.size() < 2; i++) begin
            @(negedge clk);
            #1;
        end
        chk("rd_byte2_seen", bytes.size() >= 2, 1);
        wc.txe = 1'b1;
        for (int i = 0; i < 20 && wc.wr; i++) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wc.wr) bad++;
        end
        chk("rd_txe_stall", bad, 0);
        wc.txe = 1'b0;
        wait_done(300, got);
        chk("rd_done", got, 1);
        @(negedge clk);
        chk("rd_nbytes", bytes.size(), 4);
        if (bytes.size() == 4) begin
            chk("rd_byte0", bytes[0], 8'h34);
            chk("rd_byte1", bytes[1], 8'h12);
            chk("rd_byte2", bytes[2], 8'hCD);
            chk("rd_byte3", bytes[3], 8'hAB);
        end
        for (int i = 0; i < lens.size(); i++) chk("rd_wr_len", lens[i], 5);
        chk("rd_usb_oe", oe_bad, 0);

        // async reset mid-byte
        issue(8'd4, 2'd0, 20'd0);
        issue(8'd5, 2'd0, 20'd2);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (wc.wr) got = 1'b1;
        end
        chk("rst_rd_wr_seen", got, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstrd_wr", wc.wr, 0);
        chk("rstrd_usb_oe", wc.usb_oe, 0);
        chk("rstrd_stat", wc.stat, 0);
        chk("rstrd_cex", wc.cex, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rstrd_busy_after", wc.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
